// File: rtl/tone_pkg.sv
// Shared note table and type definitions for the tone generator and detector.
package tone_pkg;

  localparam int NUM_NOTES = 8;

  // Half-period of each note in microseconds, C4 up to C5.
  localparam int NOTE_US [0:NUM_NOTES-1] = '{1911, 1703, 1517, 1432, 1276, 1136, 1012, 956};

  // Note indices as reported on note_id.
  typedef enum logic [2:0] {
    NOTE_C4 = 3'd0,
    NOTE_D4 = 3'd1,
    NOTE_E4 = 3'd2,
    NOTE_F4 = 3'd3,
    NOTE_G4 = 3'd4,
    NOTE_A4 = 3'd5,
    NOTE_B4 = 3'd6,
    NOTE_C5 = 3'd7
  } note_t;

  // Detector state encoding.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // Half-period of table entry idx in clock cycles for an m MHz clock.
  function automatic longint note_cycles(input int m, input int idx);
    return longint'(m) * longint'(NOTE_US[idx]);
  endfunction

endpackage

// File: rtl/tone_classifier.sv
// Combinational classifier: matches a measured half-period against the note table.
module tone_classifier
  import tone_pkg::*;
#(
  parameter int M      = 20,
  parameter int N      = 20,
  parameter int TOL_US = 16
) (
  input  logic [N:0] meas,
  output logic       hit,
  output note_t      hid
);

  localparam longint TOL_CYC = longint'(M) * longint'(TOL_US);
  localparam longint CNT_LIM = longint'(1) << (N + 1);

  logic [NUM_NOTES-1:0] match;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_NOTES; gi++) begin : g_note
      localparam longint     CTR  = note_cycles(M, gi);
      localparam longint     LO_L = (CTR > TOL_CYC) ? (CTR - TOL_CYC) : 64'sd0;
      localparam longint     HI_L = CTR + TOL_CYC;
      localparam logic [N:0] LO   = (N+1)'(LO_L);
      localparam logic [N:0] HI   = (N+1)'(HI_L);

      // A window that does not fit the counter width is a configuration error.
      if (HI_L >= CNT_LIM) begin : g_overflow
        $error("tone_classifier: note window exceeds counter width");
      end

      assign match[gi] = (meas >= LO) && (meas <= HI);
    end
  endgenerate

  // Priority select: windows never overlap, but the lowest index wins anyway.
  always_comb begin
    hit = |match;
    hid = NOTE_C4;
    for (int i = NUM_NOTES - 1; i >= 0; i--) begin
      if (match[i]) hid = note_t'(3'(i));
    end
  end

endmodule

// File: rtl/tone_detector.sv
// Square-wave note detector: synchronises tone_in, measures half-periods and
// locks onto one of eight notes after LOCK_N consecutive matches.
module tone_detector
  import tone_pkg::*;
#(
  parameter int M          = 20,
  parameter int N          = 20,
  parameter int TOL_US     = 16,
  parameter int LOCK_N     = 4,
  parameter int TIMEOUT_US = 4000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tone_in,
  output logic       note_valid,
  output logic [2:0] note_id,
  output logic       note_change,
  output logic [N:0] half_period
);

  localparam longint     T_OUT_L  = longint'(M) * longint'(TIMEOUT_US);
  localparam logic [N:0] T_OUT    = (N+1)'(T_OUT_L);
  localparam logic [N:0] ONE      = (N+1)'(1);
  localparam logic [3:0] LOCK_CNT = 4'(LOCK_N);

  // meas = T_OUT+1 must still be representable, and mcnt is four bits.
  if (T_OUT_L + 1 >= (longint'(1) << (N + 1))) begin : g_bad_timeout
    $error("tone_detector: timeout does not fit counter width");
  end
  if (LOCK_N < 1 || LOCK_N > 15) begin : g_bad_lock
    $error("tone_detector: LOCK_N must be in 1..15");
  end

  logic       tone_s1, tone_s2, tone_s3;
  logic       edge_pulse;
  logic [N:0] cnt;
  logic [N:0] meas;
  logic       hit;
  note_t      hid;
  state_t     state;
  note_t      cand;
  logic [3:0] mcnt;
  logic       match_run;
  logic [3:0] mcnt_upd;

  // Two-flop synchroniser plus one delay flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tone_s1 <= 1'b0;
      tone_s2 <= 1'b0;
      tone_s3 <= 1'b0;
    end else begin
      tone_s1 <= tone_in;
      tone_s2 <= tone_s1;
      tone_s3 <= tone_s2;
    end
  end

  assign edge_pulse = tone_s2 ^ tone_s3;
  assign meas       = cnt + ONE;

  // Cycles since the last edge, saturating at the silence threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (edge_pulse) begin
      cnt <= '0;
    end else if (cnt != T_OUT) begin
      cnt <= cnt + ONE;
    end
  end

  // Capture the completed half-period on every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_period <= '0;
    end else if (edge_pulse) begin
      half_period <= meas;
    end
  end

  tone_classifier #(
    .M      (M),
    .N      (N),
    .TOL_US (TOL_US)
  ) u_classifier (
    .meas (meas),
    .hit  (hit),
    .hid  (hid)
  );

  // A run continues only when the same note matches again after a prior match.
  assign match_run = hit && (hid == cand) && (mcnt != 4'd0);
  assign mcnt_upd  = match_run ? (mcnt + 4'd1) : {3'b000, hit};

  // Lock FSM with registered outputs; an edge takes priority over timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cand        <= NOTE_C4;
      mcnt        <= '0;
      note_valid  <= 1'b0;
      note_id     <= '0;
      note_change <= 1'b0;
    end else begin
      note_change <= 1'b0;
      if (edge_pulse) begin
        case (state)
          ST_IDLE: begin
            state <= ST_MEASURE;
            mcnt  <= '0;
          end
          ST_MEASURE: begin
            cand <= hid;
            mcnt <= mcnt_upd;
            if (mcnt_upd == LOCK_CNT) begin
              state       <= ST_LOCKED;
              note_valid  <= 1'b1;
              note_id     <= hid;
              note_change <= 1'b1;
            end
          end
          ST_LOCKED: begin
            if (!(hit && (hid == note_id))) begin
              state      <= ST_MEASURE;
              note_valid <= 1'b0;
              cand       <= hid;
              mcnt       <= {3'b000, hit};
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end else if (cnt == T_OUT) begin
        state      <= ST_IDLE;
        note_valid <= 1'b0;
        mcnt       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tone_detector.sv
// Directed bench for tone_detector. Runs with a 1 MHz scale (M=1) so that one
// table microsecond is one clock: A4 = 1136, tolerance = 16, timeout = 4000.
`timescale 1ns/1ps
module tb_tone_detector;

  localparam int M          = 1;
  localparam int N          = 20;
  localparam int TOL_US     = 16;
  localparam int LOCK_N     = 4;
  localparam int TIMEOUT_US = 4000;
  localparam int T_OUT      = M * TIMEOUT_US;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tone_in = 1'b0;
  logic       note_valid;
  logic [2:0] note_id;
  logic       note_change;
  logic [N:0] half_period;

  int vec_cnt = 0;
  int miscompares = 0;
  int pulse_cnt = 0;
  int consumed = 0;
  logic [4:1] nc;

  always #5 clk = ~clk;

  tone_detector #(
    .M          (M),
    .N          (N),
    .TOL_US     (TOL_US),
    .LOCK_N     (LOCK_N),
    .TIMEOUT_US (TIMEOUT_US)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tone_in     (tone_in),
    .note_valid  (note_valid),
    .note_id     (note_id),
    .note_change (note_change),
    .half_period (half_period)
  );

  // Every sampled high cycle of note_change; a long pulse inflates the count.
  always @(negedge clk) begin
    if (note_change === 1'b1) pulse_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vec_cnt++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  // Toggle tone_in d clocks after the previous toggle, then sample note_change
  // on the next four falling edges; outputs for this edge are settled after that.
  task automatic hp(input int d);
    if (d > consumed) repeat (d - consumed) @(posedge clk);
    #1 tone_in = ~tone_in;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      nc[i] = note_change;
    end
    consumed = 3;
    $display("edge after %0d clk: valid=%0d id=%0d half_period=%0d change=%b",
             d, note_valid, note_id, half_period, nc);
  endtask

  task automatic expect_lock(input string tag, input int id);
    check({tag, " valid"}, note_valid, 1);
    check({tag, " id"}, note_id, id);
    check({tag, " change timing"}, nc, 4'b1000);
  endtask

  task automatic expect_stay(input string tag, input int id);
    check({tag, " valid"}, note_valid, 1);
    check({tag, " id"}, note_id, id);
    check({tag, " change"}, nc, 4'b0000);
  endtask

  task automatic expect_off(input string tag);
    check({tag, " valid"}, note_valid, 0);
    check({tag, " change"}, nc, 4'b0000);
  endtask

  // Apply count identical half-periods that must not yet lock.
  task automatic run_off(input string tag, input int d, input int count);
    for (int i = 0; i < count; i++) begin
      hp(d);
      expect_off(tag);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst_n   = 1'b0;
    tone_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset note_valid", note_valid, 0);
    check("reset note_id", note_id, 0);
    check("reset note_change", note_change, 0);
    check("reset half_period", half_period, 0);
    rst_n = 1'b1;

    // A4 lock: first edge ignored, then LOCK_N matching half-periods
    consumed = 0;
    hp(20);
    expect_off("A4 first edge");
    run_off("A4 counting", 1136, 3);
    hp(1136);
    expect_lock("A4 lock", 5);
    hp(1136);
    expect_stay("A4 hold", 5);
    check("A4 half_period", half_period, 1136);

    // A4 tolerance: +-16 keeps lock, +-17 drops it
    hp(1152);
    expect_stay("A4 +16", 5);
    check("A4 +16 half_period", half_period, 1152);
    hp(1120);
    expect_stay("A4 -16", 5);
    hp(1153);
    expect_off("A4 +17 drop");
    run_off("A4 relock a", 1136, 3);
    hp(1136);
    expect_lock("A4 relock a", 5);
    hp(1119);
    expect_off("A4 -17 drop");
    run_off("A4 relock b", 1136, 3);
    hp(1136);
    expect_lock("A4 relock b", 5);

    // A4 -> B4: first B4 edge drops lock, three more relock
    hp(1012);
    expect_off("B4 first edge");
    run_off("B4 counting", 1012, 2);
    hp(1012);
    expect_lock("B4 lock", 6);

    // C4 tolerance: alternating +-16 counts as one run
    hp(1927);
    expect_off("C4 +16 a");
    hp(1895);
    expect_off("C4 -16 a");
    hp(1927);
    expect_off("C4 +16 b");
    hp(1895);
    expect_lock("C4 lock", 0);
    hp(1928);
    expect_off("C4 +17 drop");
    run_off("C4 relock", 1911, 3);
    hp(1911);
    expect_lock("C4 relock", 0);
    hp(1894);
    expect_off("C4 -17 drop");

    // G4 with a short glitch half-period
    run_off("G4 counting", 1276, 3);
    hp(1276);
    expect_lock("G4 lock", 4);
    hp(250);
    expect_off("G4 glitch drop");
    run_off("G4 relock", 1276, 3);
    hp(1276);
    expect_lock("G4 relock", 4);

    // C5 lock then silence
    hp(956);
    expect_off("C5 first edge");
    run_off("C5 counting", 956, 2);
    hp(956);
    expect_lock("C5 lock", 7);
    repeat (T_OUT) @(negedge clk);
    check("silence before timeout valid", note_valid, 1);
    @(negedge clk);
    check("silence timeout valid", note_valid, 0);
    check("silence note_id held", note_id, 7);

    // Restart after silence needs 1+LOCK_N edges
    consumed = 0;
    hp(10);
    expect_off("restart first edge");
    run_off("restart counting", 956, 3);
    hp(956);
    expect_lock("restart lock", 7);

    // Asynchronous reset mid-period while locked
    repeat (200) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async reset note_valid", note_valid, 0);
    check("async reset note_id", note_id, 0);
    check("async reset note_change", note_change, 0);
    check("async reset half_period", half_period, 0);
    tone_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    consumed = 0;
    hp(10);
    expect_off("post-reset first edge");
    run_off("post-reset counting", 956, 3);
    hp(956);
    expect_lock("post-reset lock", 7);
    check("post-reset half_period", half_period, 956);

    repeat (5) @(negedge clk);
    check("note_change pulse count", pulse_cnt, 11);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
